fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that lets NUM_REQ producers share the single write port of the synchronous FIFO.
- Grants one requester at a time for a bounded burst.
- Drives the FIFO's write-enable and write-data.
- Throttles on the FIFO's full and almost-full flags.
- Sits directly in front of the FIFO's write side; the read side is untouched.

---
 rtl/fifo_arb_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 18 +
 rtl/fifo_wr_arbiter.sv | 118 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// rr_pick returns the first set bit of valid, scanning ptr, ptr+1, ... modulo n.
package fifo_arb_pkg;

    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // Descending scan so the nearest valid index after ptr is the last assignment.
    function automatic logic [2:0] rr_pick(input logic [7:0] valid, input logic [2:0] ptr,
                                           input int n);
        int idx;
        rr_pick = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (k < n) begin
                idx = int'(ptr) + k;
                if (idx >= n) idx = idx - n;
                if (valid[3'(idx)]) rr_pick = 3'(idx);
            end
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick from the requester valid vector.
// It starts at ptr and returns the first valid index, wrapping at NUM_REQ.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic               any_c,
    output logic [ID_W-1:0]    pick_c
);

    assign any_c  = |valid;
    assign pick_c = ID_W'(rr_pick(8'(valid), 3'(ptr), int'(NUM_REQ)));

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter that shares one synchronous FIFO write port among NUM_REQ producers.
// The grant and pointer state are registered. Ready and write strobes follow the grant combinationally.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned MAX_BURST = 4,
    localparam int unsigned ID_W     = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      fifo_wren,
    output logic [DATA_W-1:0]         fifo_wrdata,
    input  logic                      fifo_full,
    input  logic                      fifo_alm_full,
    output logic                      grant_vld,
    output logic [ID_W-1:0]           grant_id
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t        state, state_nxt;
    logic [ID_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [ID_W-1:0]   grant_id_nxt;
    logic [CNT_W-1:0]  beat_cnt, beat_cnt_nxt;
    logic              any_valid;
    logic [ID_W-1:0]   pick;
    logic              sel_valid;
    logic              sel_last;
    logic [DATA_W-1:0] sel_data;
    logic              xfer;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .valid  (req_valid),
        .ptr    (rr_ptr),
        .any_c  (any_valid),
        .pick_c (pick)
    );

    // Select the lane belonging to the current grant.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ARB_IDLE;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            grant_id <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            beat_cnt <= beat_cnt_nxt;
            grant_id <= grant_id_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        beat_cnt_nxt = beat_cnt;
        grant_id_nxt = grant_id;
        req_ready    = '0;
        fifo_wren    = 1'b0;
        fifo_wrdata  = '0;
        xfer         = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (!fifo_alm_full && any_valid) begin
                    grant_id_nxt = pick;
                    beat_cnt_nxt = '0;
                    state_nxt    = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    req_ready[i] = (grant_id == ID_W'(i)) && !fifo_full;
                end
                xfer = sel_valid && !fifo_full;
                if (xfer) begin
                    fifo_wren    = 1'b1;
                    fifo_wrdata  = sel_data;
                    beat_cnt_nxt = beat_cnt + CNT_W'(1);
                    // A beat that is both last and at the burst limit releases only once.
                    if (sel_last || beat_cnt == CNT_W'(MAX_BURST - 1)) begin
                        state_nxt    = ARB_IDLE;
                        grant_id_nxt = '0;
                        beat_cnt_nxt = '0;
                        rr_ptr_nxt   = (grant_id == ID_W'(NUM_REQ - 1)) ? '0
                                                                         : grant_id + ID_W'(1);
                    end
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    assign grant_vld = (state == ARB_GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter. A behavioural arbiter model is
// compared against the DUT every cycle, and directed scenarios add literal expectations.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid, req_last, req_ready;
    logic [N*DW-1:0] req_data;
    logic            fifo_wren;
    logic [DW-1:0]   fifo_wrdata;
    logic            fifo_full, fifo_alm_full;
    logic            grant_vld;
    logic [1:0]      grant_id;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_last      (req_last),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .fifo_wren     (fifo_wren),
        .fifo_wrdata   (fifo_wrdata),
        .fifo_full     (fifo_full),
        .fifo_alm_full (fifo_alm_full),
        .grant_vld     (grant_vld),
        .grant_id      (grant_id)
    );

    always #5 clk = ~clk;

    // Stimulus that the next cycle applies.
    logic [N-1:0]  v_valid, v_last;
    logic [DW-1:0] v_data [N];
    logic          v_full, v_alm, v_rst;

    // Behavioural model of the arbiter.
    bit m_gnt;
    int m_gid, m_ptr, m_beats;
    int wait_grants [N];

    // DUT outputs sampled in the last cycle.
    logic          s_vld, s_wren;
    logic [1:0]    s_gid;
    logic [N-1:0]  s_ready, last_acc;
    logic [DW-1:0] s_wrdata;

    int n_checks, n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gnt = 0; m_gid = 0; m_ptr = 0; m_beats = 0;
        for (int i = 0; i < N; i++) wait_grants[i] = 0;
    endtask

    // Run one clock: drive at negedge, compare after settling, then advance the model.
    task automatic cycle();
        logic          exp_wren;
        logic [N-1:0]  exp_ready;
        logic [DW-1:0] exp_data;
        @(negedge clk);
        rst           = v_rst;
        req_valid     = v_valid;
        req_last      = v_last;
        fifo_full     = v_full;
        fifo_alm_full = v_alm;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = v_data[i];
        if (v_rst) model_reset();
        #1;
        exp_wren  = m_gnt && !v_full && v_valid[m_gid];
        exp_ready = (m_gnt && !v_full) ? (N'(1) << m_gid) : '0;
        exp_data  = exp_wren ? v_data[m_gid] : '0;
        s_vld = grant_vld; s_gid = grant_id; s_ready = req_ready;
        s_wren = fifo_wren; s_wrdata = fifo_wrdata;
        chk("grant_vld", grant_vld, m_gnt);
        chk("grant_id", grant_id, m_gnt ? m_gid : 0);
        chk("req_ready", req_ready, exp_ready);
        chk("fifo_wren", fifo_wren, exp_wren);
        chk("fifo_wrdata", fifo_wrdata, exp_data);
        last_acc = exp_ready & v_valid;
        if (!v_rst) begin
            if (!m_gnt) begin
                if (!v_alm && v_valid != '0) begin
                    for (int k = N - 1; k >= 0; k--)
                        if (v_valid[(m_ptr + k) % N]) m_gid = (m_ptr + k) % N;
                    m_gnt = 1; m_beats = 0;
                    for (int i = 0; i < N; i++) begin
                        if (i == m_gid) wait_grants[i] = 0;
                        else if (v_valid[i]) begin
                            wait_grants[i]++;
                            chk("fairness", 32'(wait_grants[i] < N), 1);
                        end
                    end
                end
            end else if (exp_wren) begin
                m_beats++;
                if (v_last[m_gid] || m_beats == MB) begin
                    m_gnt = 0;
                    m_ptr = (m_gid + 1) % N;
                    m_gid = 0;
                end
            end
        end
    endtask

    task automatic do_reset();
        v_rst = 1; v_valid = '0; v_last = '0; v_full = 0; v_alm = 0;
        cycle();
        cycle();
        v_rst = 0;
    endtask

    task automatic bump_data();
        for (int i = 0; i < N; i++) if (last_acc[i]) v_data[i] = v_data[i] + 8'd1;
    endtask

    initial begin
        clk = 0; rst = 1;
        req_valid = '0; req_last = '0; req_data = '0;
        fifo_full = 0; fifo_alm_full = 0;
        n_checks = 0; n_fail = 0;
        last_acc = '0;
        for (int i = 0; i < N; i++) v_data[i] = '0;
        model_reset();

        // Single requester, three beats ending with last.
        do_reset();
        v_valid = 4'b0100; v_data[2] = 8'hA1;
        cycle();
        chk("t1_idle_c0", s_vld, 0);
        cycle();
        chk("t1_gid", s_gid, 2);
        chk("t1_beat1", {s_wren, s_wrdata}, {1'b1, 8'hA1});
        v_data[2] = 8'hA2;
        cycle();
        chk("t1_beat2", {s_wren, s_wrdata}, {1'b1, 8'hA2});
        v_data[2] = 8'hA3; v_last = 4'b0100;
        cycle();
        chk("t1_beat3", {s_wren, s_wrdata}, {1'b1, 8'hA3});
        v_valid = 4'b1111; v_last = '0;
        cycle();
        chk("t1_released", s_vld, 0);
        cycle();
        chk("t1_next_gid", s_gid, 3);

        // All requesters valid, no last: 4-beat bursts with one idle cycle between them.
        do_reset();
        v_valid = 4'b1111; v_last = '0;
        for (int i = 0; i < N; i++) v_data[i] = 8'(16 * i);
        for (int c = 0; c < 25; c++) begin
            bump_data();
            cycle();
            chk("t2_wren", s_wren, (c % 5) != 0);
            if ((c % 5) != 0) chk("t2_gid", s_gid, ((c - 1) / 5) % 4);
        end

        // Three full cycles after beat 2 of a burst.
        do_reset();
        v_valid = 4'b0001; v_data[0] = 8'h10; last_acc = '0;
        for (int c = 0; c < 9; c++) begin
            bump_data();
            v_full = (c >= 3 && c <= 5);
            cycle();
            if (c >= 3 && c <= 5) begin
                chk("t3_ready_stall", s_ready, 0);
                chk("t3_wren_stall", s_wren, 0);
            end else if (c >= 1 && c <= 7) begin
                chk("t3_beat", {s_wren, s_wrdata}, {1'b1, 8'(8'h10 + (c < 3 ? c - 1 : c - 4))});
            end else if (c == 8) begin
                chk("t3_released", s_vld, 0);
            end
        end
        v_full = 0;

        // Almost-full blocks new grants while idle.
        do_reset();
        v_valid = 4'b1111; v_alm = 1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("t4_blocked", s_vld, 0);
        end
        v_alm = 0;
        cycle();
        cycle();
        chk("t4_grant_vld", s_vld, 1);
        chk("t4_grant_id", s_gid, 0);

        // Last coincides with the burst limit.
        do_reset();
        v_valid = 4'b0010; v_data[1] = 8'h50; last_acc = '0;
        cycle();
        for (int b = 0; b < 4; b++) begin
            bump_data();
            v_last = (b == 3) ? 4'b0010 : 4'b0000;
            cycle();
            chk("t5_beat", {s_wren, s_wrdata}, {1'b1, 8'(8'h50 + b)});
        end
        v_valid = 4'b1111; v_last = '0;
        cycle();
        chk("t5_single_release", s_vld, 0);
        cycle();
        chk("t5_next_gid", s_gid, 2);

        // Reset during a burst of requester 3.
        do_reset();
        v_valid = 4'b1000; v_data[3] = 8'h30; last_acc = '0;
        cycle();
        cycle();
        chk("t6_gid", s_gid, 3);
        chk("t6_beat1", {s_wren, s_wrdata}, {1'b1, 8'h30});
        bump_data();
        cycle();
        bump_data();
        v_rst = 1;
        cycle();
        chk("t6_rst_out", {s_vld, s_gid, s_ready, s_wren, s_wrdata}, 0);
        v_rst = 0;
        cycle();
        chk("t6_idle", s_vld, 0);
        cycle();
        chk("t6_regrant", s_gid, 3);
        chk("t6_first_write", {s_wren, s_wrdata}, {1'b1, 8'h32});

        // Random traffic with stall, almost-full and occasional reset.
        do_reset();
        last_acc = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!v_valid[i] || last_acc[i]) begin
                    v_valid[i] = ($urandom_range(0, 99) < 60);
                    v_data[i]  = 8'($urandom);
                    v_last[i]  = ($urandom_range(0, 3) == 0);
                end
            end
            v_full = ($urandom_range(0, 9) < 2);
            v_alm  = v_full | ($urandom_range(0, 9) < 2);
            v_rst  = ($urandom_range(0, 499) == 0);
            cycle();
        end
        v_rst = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
